id_issue_stage: RTL

ID_ISSUE_STAGE -- requirements
Module: id_issue_stage

---
 rtl/id_issue_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// Decode/issue stage: one holding register, 32-entry write scoreboard, registered issue bundle.
// Optional macro ID_WB_BYPASS_EN lets a same-cycle writeback clear a scoreboard hazard.
module id_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  output logic [4:0]  rR1_addr,
  output logic [4:0]  rR2_addr,
  output logic        rR1_en,
  output logic        rR2_en,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [5:0]  ex_opcode,
  output logic [4:0]  ex_rd,
  output logic        ex_wen
);

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic       wen;
  } issue_t;

  logic        held_valid_q, held_valid_d;
  logic [15:0] held_instr_q, held_instr_d;
  logic        ex_valid_q, ex_valid_d;
  issue_t      ex_q, ex_d;
  logic [31:0] sb_q, sb_d;

  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, wen;
  logic [31:0] wb_clr, sb_set, sb_eff;
  logic        hazard, issue, accept;

  assign opcode = held_instr_q[15:10];
  assign rs1    = held_instr_q[9:5];
  assign rd     = held_instr_q[9:5];
  assign rs2    = held_instr_q[4:0];

  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
    wen     = 1'b0;
    case (opcode[5:4])
      2'b00:   wen = 1'b1;
      2'b01: begin
        use_rs1 = 1'b0;
        wen     = 1'b1;
      end
      2'b10:   wen = 1'b0;
      default: begin
        if (opcode == 6'h3F) begin
          use_rs1 = 1'b0;
          use_rs2 = 1'b0;
        end
      end
    endcase
  end

  assign wb_clr = wb_en ? (32'd1 << wb_addr) : 32'd0;

`ifdef ID_WB_BYPASS_EN
  assign sb_eff = sb_q & ~wb_clr;
`else
  assign sb_eff = sb_q;
`endif

  // RAW on either source, WAW on the destination
  assign hazard = (use_rs1 & sb_eff[rs1]) | (use_rs2 & sb_eff[rs2]) | (wen & sb_eff[rd]);
  assign issue  = held_valid_q & ~hazard & (~ex_valid_q | ex_ready) & ~flush;
  assign if_ready = reset & (~held_valid_q | issue);
  assign accept = if_valid & if_ready & ~flush;

  assign rR1_addr = rs1;
  assign rR2_addr = rs2;
  assign rR1_en   = issue & use_rs1;
  assign rR2_en   = issue & use_rs2;

  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_q.opcode;
  assign ex_rd     = ex_q.rd;
  assign ex_wen    = ex_q.wen;

  always_comb begin
    held_valid_d = held_valid_q;
    held_instr_d = held_instr_q;
    if (issue) held_valid_d = 1'b0;
    if (accept) begin
      held_valid_d = 1'b1;
      held_instr_d = if_instr;
    end
    if (flush) held_valid_d = 1'b0;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (ex_ready) ex_valid_d = 1'b0;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_d       = '{opcode: opcode, rd: rd, wen: wen};
    end
    if (flush) ex_valid_d = 1'b0;
  end

  // set wins over a same-cycle clear; r0 is never tracked
  always_comb begin
    sb_set = (issue && wen && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
    sb_d   = (sb_q & ~wb_clr) | sb_set;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid_q <= 1'b0;
      held_instr_q <= '0;
      ex_valid_q   <= 1'b0;
      ex_q         <= '0;
      sb_q         <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      held_instr_q <= held_instr_d;
      ex_valid_q   <= ex_valid_d;
      ex_q         <= ex_d;
      sb_q         <= sb_d;
    end
  end

endmodule
